// File: rtl/instr_fetch.sv
// Instruction fetch stage with an IF/ID pipeline register.
//
// Keeps a byte PC and presents the matching word address to a zero-latency
// instruction ROM. On each unstalled edge the returned word is captured into
// the IF/ID register, together with PC+4. A jump or taken branch moves the PC
// to the word-aligned target and inserts one bubble (a NOP with valid_out=0).
// A jump wins over a taken branch. A redirect wins over a stall.
//
// Parameters:
//   address_data  width of the PC, the addresses and the instruction words
//   reset_pc      byte PC loaded on reset
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold the PC and the IF/ID register this cycle
//   branch_taken   redirect to branch_target
//   branch_target  byte target for a branch
//   jump           redirect to jump_target (priority over branch_taken)
//   jump_target    byte target for a jump
//   i_in           instruction word returned combinationally by the ROM
//   address        word address to the ROM ({2'b00, pc[msb:2]})
//   instr_out      IF/ID instruction (0 when valid_out=0)
//   pc_plus4_out   IF/ID PC+4 of instr_out
//   valid_out      instr_out is a real instruction, not a bubble
module instr_fetch #(
  parameter int unsigned             address_data = 32,
  parameter logic [address_data-1:0] reset_pc     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [address_data-1:0] branch_target,
  input  logic                    jump,
  input  logic [address_data-1:0] jump_target,
  input  logic [address_data-1:0] i_in,
  output logic [address_data-1:0] address,
  output logic [address_data-1:0] instr_out,
  output logic [address_data-1:0] pc_plus4_out,
  output logic                    valid_out
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e                  state_q;
  logic [address_data-1:0] pc_q;
  logic [address_data-1:0] pc_plus4;
  logic [address_data-1:0] target_sel;
  logic [address_data-1:0] target_aligned;
  logic                    redirect;

  always_comb begin
    redirect       = jump | branch_taken;
    target_sel     = jump ? jump_target : branch_target;
    target_aligned = target_sel & ~address_data'(3);
    // Wraps modulo 2^address_data by construction.
    pc_plus4       = pc_q + address_data'(4);
    address        = {2'b00, pc_q[address_data-1:2]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_q         <= reset_pc;
      instr_out    <= '0;
      pc_plus4_out <= '0;
      valid_out    <= 1'b0;
    end else if (redirect) begin
      // Redirect is honoured in every state, even under stall, and drops the
      // word fetched this cycle in favour of a bubble.
      state_q   <= StFlush;
      pc_q      <= target_aligned;
      instr_out <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        // BOOT fetches reset_pc straight away; FLUSH fetches from the new PC.
        StBoot, StRun, StFlush: begin
          state_q      <= StRun;
          pc_q         <= pc_plus4;
          instr_out    <= i_in;
          pc_plus4_out <= pc_plus4;
          valid_out    <= 1'b1;
        end
        default: begin
          state_q   <= StBoot;
          pc_q      <= reset_pc;
          instr_out <= '0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter address_data, default 32: width of PC, addresses, instruction words.
REQ-002 Parameter reset_pc, default 32'h00000000: byte PC loaded on reset.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 branch_taken  input  1  redirect PC to branch_target.
REQ-007 branch_target  input  address_data  byte target for branch.
REQ-008 jump  input  1  redirect PC to jump_target; priority over branch_taken.
REQ-009 jump_target  input  address_data  byte target for jump.
REQ-010 i_in  input  address_data  instruction returned combinationally by instruction ROM.
REQ-011 address  output  address_data  word address to instruction ROM.
REQ-012 instr_out  output  address_data  IF/ID registered instruction.
REQ-013 pc_plus4_out  output  address_data  IF/ID registered PC+4 of instr_out.
REQ-014 valid_out  output  1  instr_out is a real instruction, not a bubble.

Function
REQ-015 Internal byte PC register; address SHALL equal {2'b00, pc[address_data-1:2]} combinationally, same cycle.
REQ-016 ROM read SHALL be zero-latency: i_in sampled at the same clock edge that advances the PC.
REQ-017 FSM SHALL have states BOOT, RUN, FLUSH.
REQ-018 BOOT: entered on reset; first edge after reset release SHALL capture i_in at reset_pc, set valid_out=1, go to RUN (no bubble).
REQ-019 RUN, no stall, no redirect: each edge SHALL load instr_out<=i_in, pc_plus4_out<=pc+4, valid_out<=1, pc<=pc+4.
REQ-020 Redirect (jump or branch_taken) SHALL load pc<=target with bits [1:0] forced to 0, instr_out<=0, valid_out<=0, and enter FLUSH.
REQ-021 Target selection: jump=1 SHALL select jump_target regardless of branch_taken.
REQ-022 FLUSH SHALL last exactly one cycle, then RUN with normal fetch from the new PC; a redirect in FLUSH SHALL be honoured again (restart FLUSH).
REQ-023 Redirect SHALL take priority over stall in the same cycle.
REQ-024 stall=1 without redirect SHALL hold pc, instr_out, pc_plus4_out, valid_out and state unchanged.
REQ-025 stall in BOOT SHALL hold BOOT; fetch of reset_pc occurs on first unstalled edge.
REQ-026 PC arithmetic SHALL be modulo 2^address_data: pc=32'hFFFFFFFC increments to 32'h00000000.
REQ-027 pc_plus4_out SHALL use the same modulo rule.
REQ-028 instr_out SHALL be 0 (MIPS NOP) whenever valid_out=0.

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, set pc=reset_pc, instr_out=0, pc_plus4_out=0, valid_out=0, state=BOOT.
REQ-030 reset asserted mid-operation, including during FLUSH or stall, SHALL discard in-flight instruction and redirect with the same values.
REQ-031 All registers SHALL be held at reset values while reset=1, regardless of clock.

Verification
REQ-032 Reset then 4 unstalled edges, ROM word n = 32'h1000_0000+n -> address 0,1,2,3,4; instr_out 10000000..10000003; pc_plus4_out 4,8,12,16; valid_out 1 from edge 1.
REQ-033 stall=1 for 3 cycles at pc=8 -> address stays 2, instr_out/pc_plus4_out/valid_out unchanged; resumes at pc=8 after release.
REQ-034 branch_taken=1, branch_target=32'h43 -> next pc=32'h40, address=32'h10, valid_out=0, instr_out=0 for one cycle, then instr_out=ROM[16], pc_plus4_out=32'h44.
REQ-035 jump=1 (jump_target=32'h20) and branch_taken=1 (branch_target=32'h60) with stall=1 in same cycle -> pc=32'h20, one bubble, stall ignored.
REQ-036 reset_pc=32'hFFFFFFFC, reset release, 2 edges -> pc 32'hFFFFFFFC then 0; pc_plus4_out=0 on first fetch.
REQ-037 reset pulsed asynchronously between edges during FLUSH -> outputs zero at once, pc=reset_pc, no glitch fetch; normal BOOT sequence after release.
